// File: rtl/wave_capture.sv
// Acquisition front end: timebase decimation, level/slope trigger with auto timeout,
// ping-pong capture of one frame and per-column replay of the displayed bank.

module wave_capture_bank #(
    parameter int DEPTH = 200,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register clears on reset so the replayed sample starts at 0; array is untouched.
    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

module wave_capture #(
    parameter int H_START   = 100,
    parameter int H_LEN     = 200,
    parameter int V_START   = 200,
    parameter int V_LEN     = 256,
    parameter int SWAP_LINE = 480,
    parameter int AUTO_TO   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] adc_data,
    input  logic [3:0] div_sel,
    input  logic [7:0] trig_level,
    input  logic       trig_slope,
    input  logic       auto_mode,
    input  logic       hold,
    input  logic [9:0] value_x,
    input  logic [9:0] value_y,
    output logic [7:0] wave_data,
    output logic       frame_ready,
    output logic       trig_seen
);
    localparam int AW = $clog2(H_LEN);
    localparam int TW = $clog2(AUTO_TO) + 1;
    localparam logic [9:0] X_LO   = 10'(H_START);
    localparam logic [9:0] X_HI   = 10'(H_START + H_LEN);
    localparam logic [9:0] Y_LO   = 10'(V_START);
    localparam logic [9:0] Y_HI   = 10'(V_START + V_LEN);
    localparam logic [9:0] SWAP_Y = 10'(SWAP_LINE);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t        state;
    logic [15:0]   div_cnt, div_lim;
    logic          strobe;
    logic [7:0]    prev_smp;
    logic [TW-1:0] to_cnt;
    logic [AW-1:0] wr_ptr, wr_addr, rd_addr;
    logic          bank_sel, rd_bank, trig_flag;
    logic          trig_hit, force_hit, start_cap, wr_en, do_swap, in_win;
    logic [1:0][7:0] bank_rdata;

    // Timebase. A div_sel shrink that leaves div_cnt past the new limit wraps
    // to 0 without a strobe instead of running all the way round the counter.
    assign div_lim = (16'd1 << div_sel) - 16'd1;
    assign strobe  = (div_cnt == div_lim);

    always_ff @(posedge clk) begin
        if (!rst_n)                div_cnt <= '0;
        else if (div_cnt >= div_lim) div_cnt <= '0;
        else                       div_cnt <= div_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      prev_smp <= '0;
        else if (strobe) prev_smp <= adc_data;
    end

    // adc_data is the sample being strobed now; prev_smp is the one before it.
    always_comb begin
        if (trig_slope) trig_hit = (prev_smp < trig_level) && (adc_data >= trig_level);
        else            trig_hit = (prev_smp > trig_level) && (adc_data <= trig_level);
    end

    assign force_hit = auto_mode && (to_cnt == TW'(AUTO_TO - 1));
    assign start_cap = (state == WAIT_TRIG) && strobe && (trig_hit || force_hit);
    assign wr_en     = start_cap || ((state == CAPTURE) && strobe);
    assign wr_addr   = (state == CAPTURE) ? wr_ptr : '0;
    assign do_swap   = (state == DONE) && (value_y == SWAP_Y) && (value_x == '0) && !hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            to_cnt      <= '0;
            bank_sel    <= 1'b0;
            trig_flag   <= 1'b0;
            frame_ready <= 1'b0;
            trig_seen   <= 1'b0;
        end else begin
            frame_ready <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    state  <= ARM;
                end
                ARM: if (strobe) state <= WAIT_TRIG;
                WAIT_TRIG: if (strobe) begin
                    if (trig_hit || force_hit) begin
                        // Sample 0 is written this cycle, capture resumes at 1.
                        trig_flag <= trig_hit;
                        wr_ptr    <= AW'(1);
                        to_cnt    <= '0;
                        state     <= CAPTURE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CAPTURE: if (strobe) begin
                    if (wr_ptr == AW'(H_LEN - 1)) begin
                        wr_ptr <= '0;
                        state  <= DONE;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                DONE: if (do_swap) begin
                    bank_sel    <= ~bank_sel;
                    frame_ready <= 1'b1;
                    trig_seen   <= trig_flag;
                    state       <= ARM;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read path: rd_bank remembers which bank produced the held sample.
    assign in_win  = (value_x >= X_LO) && (value_x < X_HI) && (value_y >= Y_LO) && (value_y < Y_HI);
    assign rd_addr = AW'(value_x - X_LO);

    always_ff @(posedge clk) begin
        if (!rst_n)      rd_bank <= 1'b0;
        else if (in_win) rd_bank <= bank_sel;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wave_capture_bank #(.DEPTH(H_LEN), .AW(AW)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_en && (bank_sel != 1'(b))),
            .waddr (wr_addr),
            .wdata (adc_data),
            .re    (in_win && (bank_sel == 1'(b))),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign wave_data = bank_rdata[rd_bank];
endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: table of directed captures, hold/reset sequences and
// random captures checked against a strobe-list trigger model.

module tb_wave_capture;
    localparam int AUTO_TO_TB = 16;
    localparam int HL         = 200;
    localparam int LOGN       = 8192;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] adc_data = '0, trig_level = '0;
    logic [3:0] div_sel = '0;
    logic       trig_slope = 1'b0, auto_mode = 1'b0, hold = 1'b0;
    logic [9:0] value_x = '0, value_y = '0;
    logic [7:0] wave_data;
    logic       frame_ready, trig_seen;

    wave_capture #(.AUTO_TO(AUTO_TO_TB)) dut (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .div_sel(div_sel),
        .trig_level(trig_level), .trig_slope(trig_slope), .auto_mode(auto_mode),
        .hold(hold), .value_x(value_x), .value_y(value_y),
        .wave_data(wave_data), .frame_ready(frame_ready), .trig_seen(trig_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode, div, lvl, slope, am, a, b, col100, col299, trig;
    } vec_t;

    int checks = 0, errors = 0;
    int n = 0, rampv = 0, mode = 0, va = 0, vb = 0;
    logic [7:0] logv [LOGN];
    logic [7:0] exp_fr [HL];
    logic       exp_tf;
    bit         exp_found;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    // Stimulus source: 0 ramp, 1 constant, 2 step at cycle 40, 3 random
    function automatic logic [7:0] gen();
        case (mode)
            0:       return 8'(rampv);
            1:       return 8'(va);
            2:       return (n < 40) ? 8'(va) : 8'(vb);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // logv[c] is the sample the DUT sees on clock c after reset release
    task automatic step();
        @(posedge clk);
        #1;
        n++;
        rampv++;
        adc_data = gen();
        if (n < LOGN) logv[n] = adc_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        rampv = 0;
        adc_data = gen();
        logv[0] = adc_data;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            step();
            if (frame_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Model: list the strobed samples, skip the first strobe after the idle clock
    // (it only primes the previous sample), then take the first trigger or the
    // AUTO_TO-th unsuccessful strobe as frame sample 0.
    task automatic run_model(input int P, input int lvl, input bit slope, input bit am);
        logic [7:0] s[$];
        int sc[$];
        int arm, start, m;
        bit hit;
        exp_found = 1'b0;
        exp_tf = 1'b0;
        arm = -1;
        start = -1;
        m = 0;
        for (int c = 0; c < n && c < LOGN; c++)
            if (c % P == P - 1) begin
                s.push_back(logv[c]);
                sc.push_back(c);
            end
        for (int j = 0; j < s.size(); j++)
            if (sc[j] >= 1) begin
                arm = j;
                break;
            end
        if (arm >= 0)
            for (int j = arm + 1; j < s.size(); j++) begin
                hit = slope ? (s[j-1] < lvl && s[j] >= lvl) : (s[j-1] > lvl && s[j] <= lvl);
                if (hit) begin start = j; exp_tf = 1'b1; break; end
                if (am && m == AUTO_TO_TB - 1) begin start = j; exp_tf = 1'b0; break; end
                m++;
            end
        if (start >= 0 && start + HL - 1 < s.size()) begin
            exp_found = 1'b1;
            for (int k = 0; k < HL; k++) exp_fr[k] = s[start + k];
        end
    endtask

    task automatic read_frame(input string tag);
        logic [7:0] last;
        value_y = 10'd300;
        for (int c = 0; c < HL; c++) begin
            value_x = 10'(100 + c);
            step();
            chk($sformatf("%s col%0d", tag, 100 + c), wave_data, exp_fr[c]);
        end
        last = exp_fr[HL-1];
        value_x = 10'd300; step(); chk({tag, " hold_x300"}, wave_data, last);
        value_x = 10'd99;  step(); chk({tag, " hold_x99"}, wave_data, last);
        value_x = 10'd150; value_y = 10'd199; step(); chk({tag, " hold_y199"}, wave_data, last);
        value_y = 10'd456; step(); chk({tag, " hold_y456"}, wave_data, last);
        value_y = 10'd455; step(); chk({tag, " read_y455"}, wave_data, exp_fr[50]);
    endtask

    task automatic frame_checks(input string tag, input int P, input int lvl,
                                input bit slope, input bit am, input bit ok);
        run_model(P, lvl, slope, am);
        chk({tag, " frame_ready"}, ok, exp_found);
        if (ok && exp_found) begin
            chk({tag, " trig_seen"}, trig_seen, exp_tf);
            value_y = 10'd300;
            step();
            chk({tag, " pulse_width"}, frame_ready, 0);
            read_frame(tag);
        end
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, " rst_wave"}, wave_data, 0);
        chk({tag, " rst_ready"}, frame_ready, 0);
        chk({tag, " rst_trig"}, trig_seen, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        bit ok, hit205;
        int pulses;
        string tag;

        tbl[0] = '{0, 0, 128, 1, 0,   0,   0, 128,  71, 1};
        tbl[1] = '{0, 0, 128, 0, 0,   0,   0,   0, 199, 1};
        tbl[2] = '{1, 0, 128, 1, 1,  50,   0,  50,  50, 0};
        tbl[3] = '{0, 3, 128, 1, 0,   0,   0, 135, 191, 1};
        tbl[4] = '{2, 0, 100, 1, 1, 100, 180, 100, 180, 0};
        tbl[5] = '{2, 0, 180, 1, 0, 100, 180, 180, 180, 1};
        tbl[6] = '{2, 0,  80, 0, 1,  80,  30,  80,  30, 0};
        tbl[7] = '{2, 0,  80, 0, 0, 120,  80,  80,  80, 1};

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("vec%0d", i);
            mode = tbl[i].mode; va = tbl[i].a; vb = tbl[i].b;
            div_sel = 4'(tbl[i].div); trig_level = 8'(tbl[i].lvl);
            trig_slope = 1'(tbl[i].slope); auto_mode = 1'(tbl[i].am);
            hold = 1'b0; value_x = '0; value_y = 10'd480;
            do_reset();
            reset_outs(tag);
            wait_frame(ok);
            frame_checks(tag, 1 << tbl[i].div, tbl[i].lvl, 1'(tbl[i].slope), 1'(tbl[i].am), ok);
            chk({tag, " trig_tbl"}, trig_seen, tbl[i].trig);
            value_y = 10'd300;
            value_x = 10'd100; step(); chk({tag, " col100_tbl"}, wave_data, tbl[i].col100);
            value_x = 10'd299; step(); chk({tag, " col299_tbl"}, wave_data, tbl[i].col299);
        end

        // Hold: second frame (level 200) must stay hidden until hold drops.
        mode = 0; div_sel = '0; trig_level = 8'd128; trig_slope = 1'b1; auto_mode = 1'b0;
        hold = 1'b0; value_x = '0; value_y = 10'd480;
        do_reset();
        wait_frame(ok);
        chk("hold first_frame", ok, 1);
        hold = 1'b1;
        trig_level = 8'd200;
        chk("hold trig_seen_a", trig_seen, 1);
        pulses = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (frame_ready === 1'b1) pulses++;
        end
        chk("hold no_pulse", pulses, 0);
        value_y = 10'd300;
        value_x = 10'd299; step(); chk("hold col299_a", wave_data, 71);
        value_x = 10'd100; #2;     chk("hold latency", wave_data, 71);
        step();                    chk("hold col100_a", wave_data, 128);
        hold = 1'b0; value_x = '0; value_y = 10'd480;
        wait_frame(ok);
        chk("hold release_swap", ok, 1);
        chk("hold trig_seen_b", trig_seen, 1);
        value_y = 10'd300;
        value_x = 10'd100; step(); chk("hold col100_b", wave_data, 200);
        value_x = 10'd299; step(); chk("hold col299_b", wave_data, 143);

        // One-clock reset while the second capture is at write pointer 77.
        mode = 0; trig_level = 8'd128; value_x = '0; value_y = 10'd480;
        do_reset();
        wait_frame(ok);
        chk("mrst first_frame", ok, 1);
        value_y = 10'd300; value_x = 10'd299; step();
        chk("mrst col299_a", wave_data, 71);
        hit205 = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (adc_data == 8'd205) begin hit205 = 1'b1; break; end
            step();
        end
        chk("mrst reach_ptr77", hit205, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        logv[0] = adc_data;
        trig_level = 8'd60;
        value_x = '0; value_y = 10'd480;
        reset_outs("mrst");
        wait_frame(ok);
        frame_checks("mrst", 1, 60, 1'b1, 1'b0, ok);

        // Random captures against the model
        for (int r = 0; r < 4; r++) begin
            tag = $sformatf("rnd%0d", r);
            mode = 3;
            div_sel = 4'($urandom_range(0, 2));
            trig_level = 8'($urandom_range(32, 223));
            trig_slope = 1'($urandom_range(0, 1));
            auto_mode = 1'($urandom_range(0, 1));
            hold = 1'b0; value_x = '0; value_y = 10'd480;
            do_reset();
            wait_frame(ok);
            frame_checks(tag, 1 << div_sel, int'(trig_level), trig_slope, auto_mode, ok);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
